pipeline_hazard_controller: RTL and testbench
=============================================

Name: pipeline_hazard_controller

Overview:
Central hazard and sequencing controller for the 5-stage MIPS pipeline (IF/ID/EX/MEM/WB). It issues PC and IF/ID write enables, per-stage flush/bubble controls and EX-stage forwarding selects. It tracks stall and flush history in an FSM with a stall watchdog and saturating performance counters. It sits beside the pipeline registers and drives their enable and flush inputs.

Parameters:
MAX_STALL, 8, consecutive stall cycles allowed before hazard_error sets (1..255)
CNT_W, 16, width of the saturating performance counters

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
rs_ID, rt_ID  in  5 each  source register fields of the instruction in ID
uses_rs_ID, uses_rt_ID  in  1 each  ID instruction actually reads rs / rt
jump_ID, jr_ID  in  1 each  ID instruction is j/jal / jr
rs_EX, rt_EX  in  5 each  source fields latched in ID/EX
MemRead_EX, RegWrite_EX  in  1 each  EX-stage control
WriteReg_EX  in  5  EX destination (after RegDst mux)
RegWrite_MEM  in  1  MEM-stage write enable
WriteReg_MEM  in  5  MEM destination
branch_taken_MEM  in  1  beq/bne resolved taken in MEM
RegWrite_WB  in  1  WB-stage write enable
WriteReg_WB  in  5  WB destination
pc_write_en  out  1  PC register load enable
if_id_write_en  out  1  IF/ID hold when 0
if_id_flush, id_ex_bubble, ex_mem_flush  out  1 each  zero control fields of that pipeline register
forward_a, forward_b  out  2 each  ALU operand select: 00 regfile, 10 EX/MEM ALUResult, 01 WB write data
state  out  2  00 RUN, 01 STALL_LU, 10 STALL_JR, 11 FLUSH
stall_cycles, flush_events  out  CNT_W each  saturating counters
hazard_error  out  1  sticky watchdog flag

Behaviour:
- Reset: while reset=1, pc_write_en=0, if_id_write_en=0, if_id_flush=id_ex_bubble=ex_mem_flush=1, forward_*=00. State=RUN, counters=0, hazard_error=0. Release takes effect on the next clk edge.
- Register $0 never matches any hazard or forwarding condition.
- Load-use (lu): MemRead_EX & WriteReg_EX matches rs_ID (uses_rs_ID) or rt_ID (uses_rt_ID).
- Jr hazard (jrh): jr_ID and rs_ID equals a destination with RegWrite set in EX, MEM or WB.
- Control priority, combinational in the same cycle: branch_taken_MEM > lu/jrh > jump_ID.
  - Branch taken: pc_write_en=1, if_id_flush=id_ex_bubble=ex_mem_flush=1.
  - lu or jrh: pc_write_en=0, if_id_write_en=0, id_ex_bubble=1.
  - jump_ID: pc_write_en=1, if_id_flush=1.
  - Otherwise: all enables 1, all flushes 0.
- Forwarding, combinational, same rule for forward_b with rt_EX:
  - forward_a=10 if RegWrite_MEM and WriteReg_MEM==rs_EX.
  - Else forward_a=01 if RegWrite_WB and WriteReg_WB==rs_EX.
  - Else forward_a=00. MEM takes precedence over WB.
- FSM, registered at posedge, next state from the current cycle's winning condition:
  - branch → FLUSH; lu → STALL_LU; jrh → STALL_JR; else RUN.
  - FLUSH always lasts exactly 1 cycle unless a new branch is taken.
- Stall-run counter: increments each cycle a stall is asserted, clears on any non-stall cycle. When it reaches MAX_STALL, hazard_error sets and holds until reset.
- stall_cycles: +1 per stall cycle. flush_events: +1 per cycle with branch_taken_MEM. Both saturate at all-ones with no wrap.
- Reset mid-stall aborts immediately: state=RUN, counters cleared.

Decomposition:
Shared package holds the state encoding (RUN/STALL_LU/STALL_JR/FLUSH), the forwarding-select constants (FWD_REG=00, FWD_WB=01, FWD_MEM=10), and REG_ZERO=5'd0. One natural sub-module: forwarding_unit, the purely combinational forward_a/forward_b logic, instantiated once.

Test Plan:
- Reset: hold reset 3 cycles → pc_write_en=0, all flushes=1, state=00, counters=0; release → RUN with pc_write_en=1 next cycle.
- lw $8 in EX (MemRead_EX=1, WriteReg_EX=8), ID add uses rs=8 → exactly 1 cycle pc_write_en=0, id_ex_bubble=1, state=01 next edge, stall_cycles=1.
- branch_taken_MEM=1 concurrent with lu → flushes all 1, pc_write_en=1, no stall, flush_events=1, state=11 then 00.
- RegWrite_MEM=1/WriteReg_MEM=9 and RegWrite_WB=1/WriteReg_WB=9, rs_EX=9 → forward_a=10; WriteReg_MEM=0, rs_EX=0 → forward_a=00.
- jr $31 in ID with RegWrite_EX on 31, then MEM, then WB → 3 stall cycles (state=10), released when the match clears; MAX_STALL=2 → hazard_error=1, sticky.
- Force stall for 2^CNT_W+5 cycles with CNT_W=4 → stall_cycles holds 15, no wrap.

Source files
------------

// File: rtl/pipeline_hazard_controller_pkg.sv
// Shared encodings for the pipeline hazard controller: FSM states,
// forwarding selects and the hard-wired zero register.
package pipeline_hazard_controller_pkg;

   typedef enum logic [1:0] {
      ST_RUN      = 2'b00,
      ST_STALL_LU = 2'b01,
      ST_STALL_JR = 2'b10,
      ST_FLUSH    = 2'b11
   } state_e;

   typedef enum logic [1:0] {
      FWD_REG = 2'b00,
      FWD_WB  = 2'b01,
      FWD_MEM = 2'b10
   } fwd_sel_e;

   localparam logic [4:0] REG_ZERO = 5'd0;

   // A destination matches a source only when it is a real register:
   // $0 is hard-wired to zero and never creates a dependency.
   function automatic logic reg_match(input logic [4:0] dest, input logic [4:0] src);
      return (dest != REG_ZERO) && (dest == src);
   endfunction

endpackage

// File: rtl/pipeline_hazard_controller_if.sv
// Bundle of pipeline-side hazard inputs and controller outputs.
// slave: the controller; master: the pipeline (or a testbench) driving it.
interface pipeline_hazard_controller_if #(
   parameter int CNT_W = 16
);
   logic [4:0]       rs_ID, rt_ID;
   logic             uses_rs_ID, uses_rt_ID;
   logic             jump_ID, jr_ID;
   logic [4:0]       rs_EX, rt_EX;
   logic             MemRead_EX, RegWrite_EX;
   logic [4:0]       WriteReg_EX;
   logic             RegWrite_MEM;
   logic [4:0]       WriteReg_MEM;
   logic             branch_taken_MEM;
   logic             RegWrite_WB;
   logic [4:0]       WriteReg_WB;

   logic             pc_write_en, if_id_write_en;
   logic             if_id_flush, id_ex_bubble, ex_mem_flush;
   logic [1:0]       forward_a, forward_b;
   logic [1:0]       state;
   logic [CNT_W-1:0] stall_cycles, flush_events;
   logic             hazard_error;

   modport slave (
      input  rs_ID, rt_ID, uses_rs_ID, uses_rt_ID, jump_ID, jr_ID,
             rs_EX, rt_EX, MemRead_EX, RegWrite_EX, WriteReg_EX,
             RegWrite_MEM, WriteReg_MEM, branch_taken_MEM,
             RegWrite_WB, WriteReg_WB,
      output pc_write_en, if_id_write_en, if_id_flush, id_ex_bubble, ex_mem_flush,
             forward_a, forward_b, state, stall_cycles, flush_events, hazard_error
   );

   modport master (
      output rs_ID, rt_ID, uses_rs_ID, uses_rt_ID, jump_ID, jr_ID,
             rs_EX, rt_EX, MemRead_EX, RegWrite_EX, WriteReg_EX,
             RegWrite_MEM, WriteReg_MEM, branch_taken_MEM,
             RegWrite_WB, WriteReg_WB,
      input  pc_write_en, if_id_write_en, if_id_flush, id_ex_bubble, ex_mem_flush,
             forward_a, forward_b, state, stall_cycles, flush_events, hazard_error
   );

endinterface

// File: rtl/pipeline_hazard_controller_forwarding_unit.sv
// EX-stage operand forwarding: picks the youngest in-flight producer
// (MEM before WB) for each ALU source, otherwise the register file.
module forwarding_unit
   import pipeline_hazard_controller_pkg::*;
(
   input  logic [4:0] rs_ex_i,
   input  logic [4:0] rt_ex_i,
   input  logic       regwrite_mem_i,
   input  logic [4:0] writereg_mem_i,
   input  logic       regwrite_wb_i,
   input  logic [4:0] writereg_wb_i,
   output fwd_sel_e   forward_a_o,
   output fwd_sel_e   forward_b_o
);

   function automatic fwd_sel_e pick(input logic [4:0] src);
      if (regwrite_mem_i && reg_match(writereg_mem_i, src)) return FWD_MEM;
      if (regwrite_wb_i  && reg_match(writereg_wb_i,  src)) return FWD_WB;
      return FWD_REG;
   endfunction

   // Operand selects are purely combinational on the current EX sources.
   always_comb begin
      forward_a_o = pick(rs_ex_i);
      forward_b_o = pick(rt_ex_i);
   end

endmodule

// File: rtl/pipeline_hazard_controller.sv
// Central hazard controller for the 5-stage pipeline: PC / IF-ID enables,
// flush and bubble controls, forwarding selects, stall/flush history FSM,
// stall watchdog and saturating performance counters.
module pipeline_hazard_controller
   import pipeline_hazard_controller_pkg::*;
#(
   parameter int MAX_STALL = 8,
   parameter int CNT_W     = 16
) (
   input logic                          clk,
   input logic                          reset,
   pipeline_hazard_controller_if.slave  hz
);

   localparam logic [7:0] MAX_STALL_C = 8'(MAX_STALL);

   logic             lu, jrh, branch, stall;
   fwd_sel_e         fwd_a, fwd_b;
   state_e           state_q, state_d;
   logic [7:0]       run_q, run_d;
   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
   logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
   logic             hazard_q, hazard_d;

   forwarding_unit u_fwd (
      .rs_ex_i        (hz.rs_EX),
      .rt_ex_i        (hz.rt_EX),
      .regwrite_mem_i (hz.RegWrite_MEM),
      .writereg_mem_i (hz.WriteReg_MEM),
      .regwrite_wb_i  (hz.RegWrite_WB),
      .writereg_wb_i  (hz.WriteReg_WB),
      .forward_a_o    (fwd_a),
      .forward_b_o    (fwd_b)
   );

   // Hazard detection: load-use against EX, jr source against any in-flight writer.
   always_comb begin
      branch = hz.branch_taken_MEM;
      lu     = hz.MemRead_EX &
               ((hz.uses_rs_ID & reg_match(hz.WriteReg_EX, hz.rs_ID)) |
                (hz.uses_rt_ID & reg_match(hz.WriteReg_EX, hz.rt_ID)));
      jrh    = hz.jr_ID &
               ((hz.RegWrite_EX  & reg_match(hz.WriteReg_EX,  hz.rs_ID)) |
                (hz.RegWrite_MEM & reg_match(hz.WriteReg_MEM, hz.rs_ID)) |
                (hz.RegWrite_WB  & reg_match(hz.WriteReg_WB,  hz.rs_ID)));
      // A taken branch squashes the stalled instruction, so it never stalls.
      stall  = ~branch & (lu | jrh);
   end

   // Pipeline controls with priority reset > branch > stall > jump.
   always_comb begin
      // NOTE: every output gets a default first so no path through the
      // if/else chain leaves it unassigned and infers a latch.
      hz.pc_write_en    = 1'b1;
      hz.if_id_write_en = 1'b1;
      hz.if_id_flush    = 1'b0;
      hz.id_ex_bubble   = 1'b0;
      hz.ex_mem_flush   = 1'b0;
      hz.forward_a      = fwd_a;
      hz.forward_b      = fwd_b;
      if (reset) begin
         hz.pc_write_en    = 1'b0;
         hz.if_id_write_en = 1'b0;
         hz.if_id_flush    = 1'b1;
         hz.id_ex_bubble   = 1'b1;
         hz.ex_mem_flush   = 1'b1;
         hz.forward_a      = FWD_REG;
         hz.forward_b      = FWD_REG;
      end else if (branch) begin
         hz.if_id_flush    = 1'b1;
         hz.id_ex_bubble   = 1'b1;
         hz.ex_mem_flush   = 1'b1;
      end else if (lu || jrh) begin
         hz.pc_write_en    = 1'b0;
         hz.if_id_write_en = 1'b0;
         hz.id_ex_bubble   = 1'b1;
      end else if (hz.jump_ID) begin
         hz.if_id_flush    = 1'b1;
      end
   end

   // Next state follows this cycle's winning condition; FLUSH falls back
   // to RUN on its own unless another branch is taken.
   always_comb begin
      state_d = ST_RUN;
      if (branch)   state_d = ST_FLUSH;
      else if (lu)  state_d = ST_STALL_LU;
      else if (jrh) state_d = ST_STALL_JR;
   end

   // Watchdog run length and saturating counters.
   always_comb begin
      run_d       = 8'd0;
      stall_cnt_d = stall_cnt_q;
      flush_cnt_d = flush_cnt_q;
      if (stall) run_d = (run_q == MAX_STALL_C) ? run_q : run_q + 8'd1;
      if (stall && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + 1'b1;
      if (branch && (flush_cnt_q != '1)) flush_cnt_d = flush_cnt_q + 1'b1;
      hazard_d = hazard_q | (run_d == MAX_STALL_C);
   end

   // State and history registers; reset aborts any stall immediately.
   always_ff @(posedge clk or posedge reset) begin
      // NOTE: non-blocking assignments so every register samples the
      // pre-edge values regardless of statement order.
      if (reset) begin
         state_q     <= ST_RUN;
         run_q       <= 8'd0;
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
         hazard_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         run_q       <= run_d;
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
         hazard_q    <= hazard_d;
      end
   end

   assign hz.state        = state_q;
   assign hz.stall_cycles = stall_cnt_q;
   assign hz.flush_events = flush_cnt_q;
   assign hz.hazard_error = hazard_q;

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Self-checking bench: table of combinational control/forwarding vectors
// through a scoreboard queue, plus hand-written multi-cycle sequences.
module tb_pipeline_hazard_controller;

   localparam int CNT_W     = 4;
   localparam int MAX_STALL = 2;

   logic clk;
   logic reset;

   pipeline_hazard_controller_if #(.CNT_W(CNT_W)) hz ();

   pipeline_hazard_controller #(.MAX_STALL(MAX_STALL), .CNT_W(CNT_W)) dut (
      .clk   (clk),
      .reset (reset),
      .hz    (hz)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic [4:0] rs_id, rt_id;
      logic       uses_rs, uses_rt, jump, jr;
      logic [4:0] rs_ex, rt_ex;
      logic       memread_ex, regwrite_ex;
      logic [4:0] wr_ex;
      logic       regwrite_mem;
      logic [4:0] wr_mem;
      logic       branch;
      logic       regwrite_wb;
      logic [4:0] wr_wb;
   } pin_t;

   // ctrl = {pc_write_en, if_id_write_en, if_id_flush, id_ex_bubble, ex_mem_flush}
   typedef struct {
      string      name;
      pin_t       i;
      logic [4:0] ctrl;
      logic [1:0] fa, fb;
   } vec_t;

   vec_t tbl[$];
   vec_t exp_q[$];

   int n_total = 0;
   int n_pass  = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   task automatic drive(input pin_t v);
      hz.rs_ID = v.rs_id;  hz.rt_ID = v.rt_id;
      hz.uses_rs_ID = v.uses_rs;  hz.uses_rt_ID = v.uses_rt;
      hz.jump_ID = v.jump;  hz.jr_ID = v.jr;
      hz.rs_EX = v.rs_ex;  hz.rt_EX = v.rt_ex;
      hz.MemRead_EX = v.memread_ex;  hz.RegWrite_EX = v.regwrite_ex;
      hz.WriteReg_EX = v.wr_ex;
      hz.RegWrite_MEM = v.regwrite_mem;  hz.WriteReg_MEM = v.wr_mem;
      hz.branch_taken_MEM = v.branch;
      hz.RegWrite_WB = v.regwrite_wb;  hz.WriteReg_WB = v.wr_wb;
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [4:0] ctrl_now();
      return {hz.pc_write_en, hz.if_id_write_en, hz.if_id_flush, hz.id_ex_bubble, hz.ex_mem_flush};
   endfunction

   function automatic vec_t mk(input string n, input pin_t i, input logic [4:0] c,
                               input logic [1:0] a, input logic [1:0] b);
      vec_t v;
      v.name = n; v.i = i; v.ctrl = c; v.fa = a; v.fb = b;
      return v;
   endfunction

   function automatic pin_t lu_pin();
      pin_t p = '0;
      p.memread_ex = 1'b1; p.wr_ex = 5'd8; p.rs_id = 5'd8; p.uses_rs = 1'b1;
      return p;
   endfunction

   task automatic do_reset();
      reset = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      drive('0);
      reset = 1'b0;
   endtask

   initial begin
      pin_t p;
      vec_t e;
      reset = 1'b1;
      drive('0);

      // ---------------- Reset behaviour ----------------
      p = '0; p.regwrite_mem = 1'b1; p.wr_mem = 5'd9; p.rs_ex = 5'd9; p.rt_ex = 5'd9;
      drive(p);
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_ctrl", ctrl_now(), 5'b00111);
      check("rst_fwd", {hz.forward_a, hz.forward_b}, 4'b0000);
      check("rst_state", hz.state, 2'b00);
      check("rst_cnt", {hz.stall_cycles, hz.flush_events, hz.hazard_error}, '0);
      next_cycle();
      drive('0);
      reset = 1'b0;
      @(negedge clk);
      check("rel_pc", ctrl_now(), 5'b11000);
      check("rel_state", hz.state, 2'b00);

      // ---------------- Combinational vector table ----------------
      tbl.push_back(mk("idle", '0, 5'b11000, 2'b00, 2'b00));
      tbl.push_back(mk("lu_rs", lu_pin(), 5'b00010, 2'b00, 2'b00));
      p = lu_pin(); p.uses_rs = 1'b0;
      tbl.push_back(mk("lu_rs_unused", p, 5'b11000, 2'b00, 2'b00));
      p = '0; p.memread_ex = 1'b1; p.wr_ex = 5'd8; p.rt_id = 5'd8; p.uses_rt = 1'b1;
      tbl.push_back(mk("lu_rt", p, 5'b00010, 2'b00, 2'b00));
      p = '0; p.memread_ex = 1'b1; p.uses_rs = 1'b1; p.uses_rt = 1'b1;
      tbl.push_back(mk("lu_zero", p, 5'b11000, 2'b00, 2'b00));
      p = lu_pin(); p.branch = 1'b1;
      tbl.push_back(mk("branch_over_lu", p, 5'b11111, 2'b00, 2'b00));
      p = '0; p.jump = 1'b1;
      tbl.push_back(mk("jump", p, 5'b11100, 2'b00, 2'b00));
      p = lu_pin(); p.jump = 1'b1;
      tbl.push_back(mk("lu_over_jump", p, 5'b00010, 2'b00, 2'b00));
      p = '0; p.jr = 1'b1; p.rs_id = 5'd31; p.regwrite_ex = 1'b1; p.wr_ex = 5'd31;
      tbl.push_back(mk("jr_ex", p, 5'b00010, 2'b00, 2'b00));
      p = '0; p.jr = 1'b1; p.rs_id = 5'd31; p.regwrite_mem = 1'b1; p.wr_mem = 5'd31;
      tbl.push_back(mk("jr_mem", p, 5'b00010, 2'b00, 2'b00));
      p = '0; p.jr = 1'b1; p.rs_id = 5'd31; p.regwrite_wb = 1'b1; p.wr_wb = 5'd31;
      tbl.push_back(mk("jr_wb", p, 5'b00010, 2'b00, 2'b00));
      p = '0; p.jr = 1'b1; p.rs_id = 5'd31; p.wr_ex = 5'd31;
      tbl.push_back(mk("jr_no_write", p, 5'b11000, 2'b00, 2'b00));
      p = '0; p.jr = 1'b1; p.regwrite_ex = 1'b1;
      tbl.push_back(mk("jr_zero", p, 5'b11000, 2'b00, 2'b00));
      p = '0; p.regwrite_mem = 1'b1; p.wr_mem = 5'd9; p.regwrite_wb = 1'b1; p.wr_wb = 5'd9; p.rs_ex = 5'd9;
      tbl.push_back(mk("fwd_mem_over_wb", p, 5'b11000, 2'b10, 2'b00));
      p = '0; p.regwrite_wb = 1'b1; p.wr_wb = 5'd7; p.rs_ex = 5'd7; p.rt_ex = 5'd7;
      tbl.push_back(mk("fwd_wb_both", p, 5'b11000, 2'b01, 2'b01));
      p = '0; p.regwrite_mem = 1'b1; p.regwrite_wb = 1'b1;
      tbl.push_back(mk("fwd_zero", p, 5'b11000, 2'b00, 2'b00));
      p = '0; p.regwrite_mem = 1'b1; p.wr_mem = 5'd5; p.rt_ex = 5'd5;
      p.regwrite_wb = 1'b1; p.wr_wb = 5'd6; p.rs_ex = 5'd6;
      tbl.push_back(mk("fwd_split", p, 5'b11000, 2'b01, 2'b10));
      p = '0; p.wr_mem = 5'd9; p.rs_ex = 5'd9; p.wr_wb = 5'd9; p.rt_ex = 5'd9;
      tbl.push_back(mk("fwd_no_write", p, 5'b11000, 2'b00, 2'b00));

      foreach (tbl[k]) begin
         next_cycle();
         drive(tbl[k].i);
         exp_q.push_back(tbl[k]);
         @(negedge clk);
         if (exp_q.size() == 0) check("sb_underflow", 1, 0);
         else begin
            e = exp_q.pop_front();
            check({e.name, "_ctrl"}, ctrl_now(), e.ctrl);
            check({e.name, "_fwd"}, {hz.forward_a, hz.forward_b}, {e.fa, e.fb});
         end
      end
      check("sb_empty", exp_q.size(), 0);

      // ---------------- Load-use single stall ----------------
      do_reset();
      drive(lu_pin());
      @(negedge clk);
      check("lu_stall_ctrl", ctrl_now(), 5'b00010);
      next_cycle();
      drive('0);
      @(negedge clk);
      check("lu_state", hz.state, 2'b01);
      check("lu_stall_cnt", hz.stall_cycles, 1);
      check("lu_released", ctrl_now(), 5'b11000);
      next_cycle();
      @(negedge clk);
      check("lu_back_run", hz.state, 2'b00);
      check("lu_cnt_hold", hz.stall_cycles, 1);

      // ---------------- Branch concurrent with load-use ----------------
      do_reset();
      p = lu_pin(); p.branch = 1'b1;
      drive(p);
      @(negedge clk);
      check("br_ctrl", ctrl_now(), 5'b11111);
      next_cycle();
      drive('0);
      @(negedge clk);
      check("br_state_flush", hz.state, 2'b11);
      check("br_flush_cnt", hz.flush_events, 1);
      check("br_no_stall", hz.stall_cycles, 0);
      next_cycle();
      @(negedge clk);
      check("br_state_run", hz.state, 2'b00);

      // ---------------- jr hazard through EX, MEM, WB ----------------
      do_reset();
      p = '0; p.jr = 1'b1; p.rs_id = 5'd31; p.regwrite_ex = 1'b1; p.wr_ex = 5'd31;
      drive(p);
      @(negedge clk);
      check("jr1_ctrl", ctrl_now(), 5'b00010);
      next_cycle();
      p = '0; p.jr = 1'b1; p.rs_id = 5'd31; p.regwrite_mem = 1'b1; p.wr_mem = 5'd31;
      drive(p);
      @(negedge clk);
      check("jr2_ctrl", ctrl_now(), 5'b00010);
      check("jr2_state", hz.state, 2'b10);
      check("jr2_no_err", hz.hazard_error, 0);
      next_cycle();
      p = '0; p.jr = 1'b1; p.rs_id = 5'd31; p.regwrite_wb = 1'b1; p.wr_wb = 5'd31;
      drive(p);
      @(negedge clk);
      check("jr3_ctrl", ctrl_now(), 5'b00010);
      check("jr3_err", hz.hazard_error, 1);
      next_cycle();
      p = '0; p.jr = 1'b1; p.rs_id = 5'd31;
      drive(p);
      @(negedge clk);
      check("jr_release", ctrl_now(), 5'b11000);
      check("jr_state", hz.state, 2'b10);
      check("jr_stall_cnt", hz.stall_cycles, 3);
      next_cycle();
      drive('0);
      @(negedge clk);
      check("jr_run", hz.state, 2'b00);
      check("err_sticky", hz.hazard_error, 1);
      reset = 1'b1;
      #1;
      check("err_cleared", hz.hazard_error, 0);

      // ---------------- Counter saturation ----------------
      do_reset();
      for (int c = 0; c < 14; c++) begin
         drive(lu_pin());
         next_cycle();
      end
      drive('0);
      @(negedge clk);
      check("stall_cnt_14", hz.stall_cycles, 14);
      for (int c = 0; c < 7; c++) begin
         next_cycle();
         drive(lu_pin());
      end
      next_cycle();
      drive('0);
      @(negedge clk);
      check("stall_cnt_sat", hz.stall_cycles, 15);
      p = '0; p.branch = 1'b1;
      for (int c = 0; c < 20; c++) begin
         next_cycle();
         drive(p);
      end
      next_cycle();
      drive('0);
      @(negedge clk);
      check("flush_cnt_sat", hz.flush_events, 15);
      check("flush_state", hz.state, 2'b11);

      // ---------------- Reset in the middle of a stall ----------------
      next_cycle();
      drive(lu_pin());
      next_cycle();
      next_cycle();
      #2;
      reset = 1'b1;
      #1;
      check("mid_rst_state", hz.state, 2'b00);
      check("mid_rst_cnt", {hz.stall_cycles, hz.flush_events}, 0);
      check("mid_rst_ctrl", ctrl_now(), 5'b00111);
      drive('0);
      next_cycle();
      reset = 1'b0;

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
